// File: rtl/iob_gray_conv_pipe_pkg.sv
// Shared constants and chunk-geometry helpers for the pipelined Gray/binary converter.
package iob_gray_conv_pipe_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    function automatic int chunk_w(input int data_w, input int stages);
        return (data_w + stages - 1) / stages;
    endfunction

    // Highest bit resolved by stage k; negative when the stage has no chunk left.
    function automatic int stage_hi(input int k, input int data_w, input int stages);
        return data_w - 1 - k * chunk_w(data_w, stages);
    endfunction

    function automatic int stage_lo(input int k, input int data_w, input int stages);
        int lo;
        lo = stage_hi(k, data_w, stages) - chunk_w(data_w, stages) + 1;
        if (lo < 0) lo = 0;
        return lo;
    endfunction

endpackage

// File: rtl/iob_gray_conv_stage.sv
// One converter pipeline stage: resolves its Gray->binary chunk for every channel
// and registers valid/mode/data when the global advance strobe is high.
module iob_gray_conv_stage
    import iob_gray_conv_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     adv,
    input  logic                     src_valid,
    input  logic                     src_mode,
    input  logic [N_CH*DATA_W-1:0]   src_data,
    output logic                     valid,
    output logic                     mode,
    output logic [N_CH*DATA_W-1:0]   data
);

    localparam int HI = stage_hi(IDX, DATA_W, STAGES);
    localparam int LO = stage_lo(IDX, DATA_W, STAGES);

    // Bits above HI arrive already binary, so bit HI chains off its resolved neighbour.
    // Binary->Gray is a single XOR level with no carry, so stage 0 does it whole.
    function automatic logic [DATA_W-1:0] convert(input logic [DATA_W-1:0] w, input logic m);
        logic [DATA_W-1:0] r;
        r = w;
        if (m == MODE_B2G) begin
            if (IDX == 0) r = w ^ (w >> 1);
        end else begin
            for (int p = DATA_W - 2; p >= 0; p--) begin
                if (p <= HI && p >= LO) r[p] = r[p+1] ^ w[p];
            end
        end
        return r;
    endfunction

    logic [N_CH*DATA_W-1:0] conv;

    // NOTE: assign a default first so no path through the block leaves conv unassigned (no latch).
    always_comb begin
        conv = '0;
        for (int c = 0; c < N_CH; c++) begin
            conv[c*DATA_W +: DATA_W] = convert(src_data[c*DATA_W +: DATA_W], src_mode);
        end
    end

    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    // NOTE: data is reset too because the last stage drives data_o, which must read 0 after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            mode  <= MODE_G2B;
            data  <= '0;
        end else if (adv) begin
            valid <= src_valid;
            mode  <= src_mode;
            data  <= conv;
        end
    end

endmodule

// File: rtl/iob_gray_conv_pipe.sv
// Pipelined multi-channel Gray<->binary converter with a global valid/ready stall.
// Optional Gray step checker enabled by defining IOB_GRAY_CONV_PIPE_STEP_CHK_EN.
module iob_gray_conv_pipe
    import iob_gray_conv_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2,
    parameter int STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     mode_i,
    input  logic [N_CH*DATA_W-1:0]   data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     mode_o,
    output logic [N_CH*DATA_W-1:0]   data_o,
    output logic [N_CH-1:0]          step_err_o
);

    logic                     adv;
    logic [STAGES:0]          v;
    logic [STAGES:0]          m;
    logic [N_CH*DATA_W-1:0]   d [STAGES+1];

    // Whole pipe moves together; a full output slot that is not taken freezes everything.
    assign adv     = cke_i & (~valid_o | ready_i);
    assign ready_o = adv;

    assign v[0] = valid_i & ready_o;
    assign m[0] = mode_i;
    assign d[0] = data_i;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        iob_gray_conv_stage #(
            .DATA_W (DATA_W),
            .N_CH   (N_CH),
            .STAGES (STAGES),
            .IDX    (g)
        ) u_stage (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .adv       (adv),
            .src_valid (v[g]),
            .src_mode  (m[g]),
            .src_data  (d[g]),
            .valid     (v[g+1]),
            .mode      (m[g+1]),
            .data      (d[g+1])
        );
    end

    assign valid_o = v[STAGES];
    assign mode_o  = m[STAGES];
    assign data_o  = d[STAGES];

`ifdef IOB_GRAY_CONV_PIPE_STEP_CHK_EN
    logic [N_CH*DATA_W-1:0] prev;
    logic                   have_prev;
    logic [N_CH-1:0]        err;
    logic                   g_acc;
    logic [N_CH*DATA_W-1:0] diff;

    function automatic logic multi_bit(input logic [DATA_W-1:0] x);
        return (x & (x - 1'b1)) != '0;
    endfunction

    assign g_acc = valid_i & ready_o & (mode_i == MODE_G2B);
    assign diff  = data_i ^ prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev      <= '0;
            have_prev <= 1'b0;
            err       <= '0;
        end else if (g_acc) begin
            prev      <= data_i;
            have_prev <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (have_prev && multi_bit(diff[c*DATA_W +: DATA_W])) err[c] <= 1'b1;
            end
        end
    end

    assign step_err_o = err;
`else
    assign step_err_o = '0;
`endif

endmodule

// File: tb/tb_iob_gray_conv_pipe.sv
// Self-checking bench for iob_gray_conv_pipe: directed vectors plus a queue-based reference model.
module tb_iob_gray_conv_pipe;

    localparam int DATA_W = 8;
    localparam int N_CH   = 2;
    localparam int STAGES = 2;
    localparam int W      = N_CH * DATA_W;

`ifdef IOB_GRAY_CONV_PIPE_STEP_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          cke_i, rst_i, valid_i, mode_i, ready_i;
    logic [W-1:0]  data_i;
    logic          ready_o, valid_o, mode_o;
    logic [W-1:0]  data_o;
    logic [N_CH-1:0] step_err_o;

    iob_gray_conv_pipe #(.DATA_W(DATA_W), .N_CH(N_CH), .STAGES(STAGES)) dut (
        .clk_i      (clk),
        .cke_i      (cke_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .mode_i     (mode_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .mode_o     (mode_o),
        .data_o     (data_o),
        .step_err_o (step_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         mode;
        logic [W-1:0] data;
    } word_t;

    word_t         exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_out   = 0;
    bit            accepted;
    bit            hold_prev = 1'b0;
    logic          sv_valid, sv_mode;
    logic [W-1:0]  sv_data;
    logic [W-1:0]  sp_prev;
    bit            sp_have = 1'b0;
    logic [N_CH-1:0] sp_err = '0;

    // Binary bit p is the parity of all Gray bits at or above p.
    function automatic logic [DATA_W-1:0] g2b(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        for (int p = 0; p < DATA_W; p++) b[p] = ^(g >> p);
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] b2g(input logic [DATA_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] model(input logic m, input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int c = 0; c < N_CH; c++)
            r[c*DATA_W +: DATA_W] = m ? b2g(d[c*DATA_W +: DATA_W]) : g2b(d[c*DATA_W +: DATA_W]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observes the handshakes that will take effect at the coming rising edge.
    task automatic observe();
        word_t e;
        check("step_err", {62'd0, step_err_o}, {62'd0, sp_err});
        if (hold_prev) begin
            check("hold_valid", {63'd0, valid_o}, {63'd0, sv_valid});
            check("hold_mode", {63'd0, mode_o}, {63'd0, sv_mode});
            check("hold_data", {48'd0, data_o}, {48'd0, sv_data});
        end
        accepted = 1'b0;
        if (rst_i) begin
            exp_q.delete();
            sp_have   = 1'b0;
            sp_err    = '0;
            hold_prev = 1'b0;
            return;
        end
        check("ready_o", {63'd0, ready_o}, {63'd0, cke_i & (~valid_o | ready_i)});
        if (valid_o && ready_i && cke_i) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", {48'd0, data_o}, 64'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check("out_mode", {63'd0, mode_o}, {63'd0, e.mode});
                check("out_data", {48'd0, data_o}, {48'd0, model(e.mode, e.data)});
            end
        end
        if (valid_i && ready_o) begin
            accepted = 1'b1;
            exp_q.push_back('{mode: mode_i, data: data_i});
            if (mode_i == 1'b0) begin
                if (sp_have && CHK)
                    for (int c = 0; c < N_CH; c++)
                        if ($countones(data_i[c*DATA_W +: DATA_W] ^ sp_prev[c*DATA_W +: DATA_W]) > 1)
                            sp_err[c] = 1'b1;
                sp_prev = data_i;
                sp_have = 1'b1;
            end
        end
        hold_prev = !cke_i || (valid_o && !ready_i);
        sv_valid  = valid_o;
        sv_mode   = mode_o;
        sv_data   = data_o;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [W-1:0] d, input bit rnd);
        valid_i = 1'b1;
        mode_i  = m;
        data_i  = d;
        for (int t = 0; t < 64; t++) begin
            if (rnd) ready_i = 1'($urandom_range(0, 1));
            step();
            if (accepted) begin
                valid_i = 1'b0;
                return;
            end
        end
        valid_i = 1'b0;
        check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        cke_i   = 1'b1;
        for (int t = 0; t < 8; t++) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_before;
        cke_i = 1'b1; rst_i = 1'b1; valid_i = 1'b0; mode_i = 1'b0; ready_i = 1'b1; data_i = '0;
        @(posedge clk); #1;
        step();
        check("rst_valid_o", {63'd0, valid_o}, 64'd0);
        check("rst_data_o", {48'd0, data_o}, 64'd0);
        check("rst_mode_o", {63'd0, mode_o}, 64'd0);
        check("rst_step_err", {62'd0, step_err_o}, 64'd0);
        rst_i = 1'b0;
        check("rst_ready_o", {63'd0, ready_o}, 64'd1);

        // Gray->binary literal vector, two-cycle latency.
        valid_i = 1'b1; mode_i = 1'b0; data_i = 16'h80C6;
        step();
        valid_i = 1'b0;
        check("lat_g2b_early", {63'd0, valid_o}, 64'd0);
        step();
        check("lat_g2b_valid", {63'd0, valid_o}, 64'd1);
        check("lit_g2b_data", {48'd0, data_o}, 64'hFF84);
        check("lit_g2b_mode", {63'd0, mode_o}, 64'd0);
        step();

        // Binary->Gray literal vector.
        valid_i = 1'b1; mode_i = 1'b1; data_i = 16'hFF84;
        step();
        valid_i = 1'b0;
        step();
        check("lit_b2g_valid", {63'd0, valid_o}, 64'd1);
        check("lit_b2g_data", {48'd0, data_o}, 64'h80C6);
        check("lit_b2g_mode", {63'd0, mode_o}, 64'd1);
        drain();

        // Alternating modes back-to-back: one word accepted and emitted every cycle.
        out_before = n_out;
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1; mode_i = i[0]; data_i = {8'(i * 37 + 5), 8'(i * 17)};
            step();
            check("b2b_accept", {63'd0, accepted}, 64'd1);
        end
        valid_i = 1'b0;
        step();
        check("b2b_steady_valid", {63'd0, valid_o}, 64'd1);
        drain();
        check("b2b_count", 64'(n_out - out_before), 64'd16);

        // Reset with two words in flight.
        send(1'b0, 16'h1234, 1'b0);
        send(1'b1, 16'h5678, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_valid_o", {63'd0, valid_o}, 64'd0);
        check("midrst_data_o", {48'd0, data_o}, 64'd0);
        out_before = n_out;
        drain();
        check("midrst_no_stale", 64'(n_out - out_before), 64'd0);

        // Gray step checker: ch0 jumps two bits, ch1 moves one.
        send(1'b0, 16'h0000, 1'b0);
        send(1'b0, 16'h0103, 1'b0);
        step();
        check("step_err_set", {62'd0, step_err_o}, CHK ? 64'd1 : 64'd0);
        send(1'b0, 16'h0102, 1'b0);
        drain();
        check("step_err_sticky", {62'd0, step_err_o}, CHK ? 64'd1 : 64'd0);

        // Gray count stream with random back-pressure and a clock-enable gap.
        out_before = n_out;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                ready_i = 1'b1;
                cke_i   = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check("cke_ready_o", {63'd0, ready_o}, 64'd0);
                end
                cke_i = 1'b1;
            end
            send(1'b0, {b2g(8'(255 - i)), b2g(8'(i))}, 1'b1);
        end
        drain();
        check("stream_count", 64'(n_out - out_before), 64'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
